// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline hazard/stall controller.
package pipe_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } pipe_state_e;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_DROP = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_stall;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_drop;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_FROZEN = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
    id_ex_flush: 1'b0, ex_stall: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_drop: 1'b0
  };

  localparam pipe_ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1, id_ex_en: 1'b0,
    id_ex_flush: 1'b1, ex_stall: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_drop: 1'b0
  };

  localparam pipe_ctrl_t CTRL_FLOW = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b0, ex_stall: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_drop: 1'b0
  };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the ID instruction reads the register an EX load writes.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic [4:0] i_ex_rd_addr,
  input  logic       i_ex_DM_OE,
  output logic       o_luse
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = i_id_use_rs1 && (i_id_rs1_addr == i_ex_rd_addr);
  assign rs2_hit = i_id_use_rs2 && (i_id_rs2_addr == i_ex_rd_addr);
  // x0 never carries a real dependency, even when a load targets it.
  assign o_luse  = i_ex_DM_OE && (i_ex_rd_addr != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller: orders bus stalls, redirects and load-use bubbles,
// discards wrong-path fetches after a redirect, and counts stall/flush events.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_DM_OE,
  input  logic             i_ex_redirect,
  input  logic             i_im_busy,
  input  logic             i_dm_busy,
  input  logic             i_cnt_clr,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_en,
  output logic             o_id_ex_flush,
  output logic             o_ex_stall,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_if_drop,
  output logic [CNT_W-1:0] o_cnt_luse,
  output logic [CNT_W-1:0] o_cnt_flush,
  output logic [CNT_W-1:0] o_cnt_bus,
  output pipe_state_e      o_dbg_state
);

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       luse;
  pipe_ctrl_t ctrl;
  logic       ev_luse;
  logic       ev_flush;
  logic       ev_bus;

  hazard_detect u_hazard_detect (
    .i_id_rs1_addr (i_id_rs1_addr),
    .i_id_rs2_addr (i_id_rs2_addr),
    .i_id_use_rs1  (i_id_use_rs1),
    .i_id_use_rs2  (i_id_use_rs2),
    .i_ex_rd_addr  (i_ex_rd_addr),
    .i_ex_DM_OE    (i_ex_DM_OE),
    .o_luse        (luse)
  );

  always_comb begin
    ctrl     = CTRL_FROZEN;
    state_d  = state_q;
    ev_luse  = 1'b0;
    ev_flush = 1'b0;
    ev_bus   = 1'b0;
    if (rst) begin
      ctrl    = CTRL_RESET;
      state_d = S_RUN;
    end else if (state_q == S_DROP) begin
      // EX holds a bubble here, so any redirect seen now is stale and ignored.
      ctrl.if_id_flush = 1'b1;
      ctrl.ex_stall    = 1'b1;
      ctrl.if_drop     = 1'b1;
      ctrl.id_ex_en    = !i_dm_busy;
      ctrl.ex_mem_en   = !i_dm_busy;
      ctrl.mem_wb_en   = !i_dm_busy;
      ev_bus           = i_im_busy;
      if (!i_im_busy) state_d = S_RUN;
    end else if (i_dm_busy) begin
      ev_bus = 1'b1;
    end else if (i_ex_redirect) begin
      ctrl             = CTRL_FLOW;
      ctrl.if_id_en    = 1'b0;
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      ev_flush         = 1'b1;
      if (i_im_busy) state_d = S_DROP;
    end else if (i_im_busy || luse) begin
      ctrl          = CTRL_FLOW;
      ctrl.pc_en    = 1'b0;
      ctrl.if_id_en = 1'b0;
      ctrl.ex_stall = 1'b1;
      ev_bus        = i_im_busy;
      ev_luse       = !i_im_busy;
    end else begin
      ctrl = CTRL_FLOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear wins over a same-cycle increment; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || i_cnt_clr) begin
      o_cnt_luse  <= '0;
      o_cnt_flush <= '0;
      o_cnt_bus   <= '0;
    end else begin
      o_cnt_luse  <= o_cnt_luse  + {{(CNT_W-1){1'b0}}, ev_luse};
      o_cnt_flush <= o_cnt_flush + {{(CNT_W-1){1'b0}}, ev_flush};
      o_cnt_bus   <= o_cnt_bus   + {{(CNT_W-1){1'b0}}, ev_bus};
    end
  end

  assign o_pc_en       = ctrl.pc_en;
  assign o_if_id_en    = ctrl.if_id_en;
  assign o_if_id_flush = ctrl.if_id_flush;
  assign o_id_ex_en    = ctrl.id_ex_en;
  assign o_id_ex_flush = ctrl.id_ex_flush;
  assign o_ex_stall    = ctrl.ex_stall;
  assign o_ex_mem_en   = ctrl.ex_mem_en;
  assign o_mem_wb_en   = ctrl.mem_wb_en;
  assign o_if_drop     = ctrl.if_drop;
  assign o_dbg_state   = pipe_state_e'(state_q);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations, then
// random traffic, all cross-checked each cycle against a behavioural model.
module tb_pipeline_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] i_id_rs1_addr = '0;
  logic [4:0] i_id_rs2_addr = '0;
  logic i_id_use_rs1 = 1'b0;
  logic i_id_use_rs2 = 1'b0;
  logic [4:0] i_ex_rd_addr = '0;
  logic i_ex_DM_OE = 1'b0;
  logic i_ex_redirect = 1'b0;
  logic i_im_busy = 1'b0;
  logic i_dm_busy = 1'b0;
  logic i_cnt_clr = 1'b0;
  logic o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush;
  logic o_ex_stall, o_ex_mem_en, o_mem_wb_en, o_if_drop;
  logic [CNT_W-1:0] o_cnt_luse, o_cnt_flush, o_cnt_bus;
  pipe_state_e o_dbg_state;

  int n_pass = 0;
  int n_total = 0;

  // model state
  bit started = 0;
  bit m_drop = 0;
  int m_luse = 0;
  int m_flush = 0;
  int m_bus = 0;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
    .i_ex_rd_addr(i_ex_rd_addr), .i_ex_DM_OE(i_ex_DM_OE),
    .i_ex_redirect(i_ex_redirect), .i_im_busy(i_im_busy), .i_dm_busy(i_dm_busy),
    .i_cnt_clr(i_cnt_clr),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_en(o_id_ex_en), .o_id_ex_flush(o_id_ex_flush), .o_ex_stall(o_ex_stall),
    .o_ex_mem_en(o_ex_mem_en), .o_mem_wb_en(o_mem_wb_en), .o_if_drop(o_if_drop),
    .o_cnt_luse(o_cnt_luse), .o_cnt_flush(o_cnt_flush), .o_cnt_bus(o_cnt_bus),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit m_hazard();
    return i_ex_DM_OE && (i_ex_rd_addr != 5'd0) &&
           ((i_id_use_rs1 && i_id_rs1_addr == i_ex_rd_addr) ||
            (i_id_use_rs2 && i_id_rs2_addr == i_ex_rd_addr));
  endfunction

  // Expected control word, bit order pc,ifid_en,ifid_fl,idex_en,idex_fl,stall,exmem,memwb,drop.
  function automatic logic [8:0] m_ctrl();
    bit go;
    go = !i_dm_busy;
    if (rst) return 9'b0_0_1_0_1_0_0_0_0;
    if (m_drop) return {1'b0, 1'b0, 1'b1, go, 1'b0, 1'b1, go, go, 1'b1};
    if (i_dm_busy) return 9'b0;
    if (i_ex_redirect) return 9'b1_0_1_1_1_0_1_1_0;
    if (i_im_busy || m_hazard()) return 9'b0_0_0_1_0_1_1_1_0;
    return 9'b1_1_0_1_0_0_1_1_0;
  endfunction

  // behavioural model: event classification and counter arithmetic
  always @(posedge clk) begin
    bit ev_bus, ev_flush, ev_luse, next_drop;
    started = 1;
    if (m_drop) begin
      ev_bus = i_im_busy; ev_flush = 0; ev_luse = 0;
      next_drop = i_im_busy;
    end else begin
      ev_bus    = i_dm_busy || (!i_ex_redirect && i_im_busy);
      ev_flush  = !i_dm_busy && i_ex_redirect;
      ev_luse   = !i_dm_busy && !i_ex_redirect && !i_im_busy && m_hazard();
      next_drop = ev_flush && i_im_busy;
    end
    if (rst || i_cnt_clr) begin
      m_luse = 0; m_flush = 0; m_bus = 0;
    end else begin
      m_luse  = (m_luse + int'(ev_luse)) % (1 << CNT_W);
      m_flush = (m_flush + int'(ev_flush)) % (1 << CNT_W);
      m_bus   = (m_bus + int'(ev_bus)) % (1 << CNT_W);
    end
    m_drop = rst ? 1'b0 : next_drop;
  end

  // compare process
  always @(negedge clk) begin
    if (started) begin
      check("ctrl", {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
                     o_ex_stall, o_ex_mem_en, o_mem_wb_en, o_if_drop}, m_ctrl());
      check("cnt_luse", o_cnt_luse, m_luse);
      check("cnt_flush", o_cnt_flush, m_flush);
      check("cnt_bus", o_cnt_bus, m_bus);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_id_rs1_addr = '0; i_id_rs2_addr = '0; i_id_use_rs1 = 0; i_id_use_rs2 = 0;
    i_ex_rd_addr = '0; i_ex_DM_OE = 0; i_ex_redirect = 0;
    i_im_busy = 0; i_dm_busy = 0; i_cnt_clr = 0;
  endtask

  task automatic clear_cnt();
    idle();
    i_cnt_clr = 1;
    tick();
    i_cnt_clr = 0;
  endtask

  task automatic set_luse(input bit on);
    i_ex_DM_OE = on; i_ex_rd_addr = 5'd1;
    i_id_use_rs1 = 1; i_id_rs1_addr = 5'd1;
    i_id_use_rs2 = 1; i_id_rs2_addr = 5'd2;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    #1;
    check("rst_flush", {o_if_id_flush, o_id_ex_flush, o_pc_en, o_ex_stall}, 4'b1100);
    tick();
    rst = 0;
    #1;
    check("rst_cnt", {o_cnt_luse, o_cnt_flush, o_cnt_bus}, 12'h000);

    // load-use: lw x1 in EX, add x3,x1,x2 in ID
    set_luse(1);
    #1;
    check("luse_stall", {o_ex_stall, o_pc_en}, 2'b10);
    tick();
    idle();
    #1;
    check("luse_cnt", o_cnt_luse, 1);
    check("luse_next", {o_ex_stall, o_pc_en}, 2'b01);

    // lw x0 with ID reading x0
    i_ex_DM_OE = 1; i_ex_rd_addr = 5'd0; i_id_use_rs1 = 1; i_id_rs1_addr = 5'd0;
    #1;
    check("x0_nostall", o_ex_stall, 0);
    tick();

    // redirect with idle buses
    clear_cnt();
    i_ex_redirect = 1;
    #1;
    check("redir_ctrl", {o_if_id_flush, o_id_ex_flush, o_pc_en, o_if_drop}, 4'b1110);
    tick();
    idle();
    #1;
    check("redir_cnt", o_cnt_flush, 1);
    check("redir_run", o_dbg_state, ST_RUN);

    // redirect with a fetch outstanding for 3 more cycles
    clear_cnt();
    i_ex_redirect = 1; i_im_busy = 1;
    tick();
    i_ex_redirect = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("drop_busy", {o_if_drop, o_pc_en}, 2'b10);
      tick();
    end
    i_im_busy = 0;
    #1;
    check("drop_resp", o_if_drop, 1);
    tick();
    #1;
    check("drop_done", o_if_drop, 0);
    check("drop_bus", o_cnt_bus, 3);

    // data bus busy 5 cycles with redirect and load-use pending
    clear_cnt();
    set_luse(1); i_ex_redirect = 1; i_dm_busy = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("dm_frozen", {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en}, 5'b0);
      tick();
    end
    i_dm_busy = 0;
    #1;
    check("dm_commit", {o_pc_en, o_id_ex_flush}, 2'b11);
    tick();
    idle();
    #1;
    check("dm_bus", o_cnt_bus, 5);
    check("dm_luse", o_cnt_luse, 0);
    check("dm_flush", o_cnt_flush, 1);

    // counter wrap and clear priority
    clear_cnt();
    i_dm_busy = 1;
    for (int i = 0; i < 15; i++) tick();
    check("wrap_15", o_cnt_bus, 15);
    tick();
    check("wrap_0", o_cnt_bus, 0);
    i_cnt_clr = 1;
    tick();
    check("clr_prio", o_cnt_bus, 0);
    idle();

    // reset in the middle of DROP
    i_ex_redirect = 1; i_im_busy = 1;
    tick();
    i_ex_redirect = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("rst_drop", {o_if_drop, o_ex_stall}, 2'b01);
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      i_id_rs1_addr = 5'($urandom_range(0, 3));
      i_id_rs2_addr = 5'($urandom_range(0, 3));
      i_id_use_rs1  = 1'($urandom_range(0, 1));
      i_id_use_rs2  = 1'($urandom_range(0, 1));
      i_ex_rd_addr  = 5'($urandom_range(0, 3));
      i_ex_DM_OE    = ($urandom_range(0, 2) == 0);
      i_ex_redirect = ($urandom_range(0, 5) == 0);
      i_im_busy     = ($urandom_range(0, 3) == 0);
      i_dm_busy     = ($urandom_range(0, 7) == 0);
      i_cnt_clr     = ($urandom_range(0, 99) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;
    idle();
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall controller for the five-stage RV32I pipeline. It watches the ID and EX stages and the AXI instruction/data bus busy flags, and drives the enable, flush and bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves priority between bus stalls, control-flow redirects and load-use hazards. It tracks a wrong-path fetch that is still outstanding when a redirect commits, and keeps performance counters for stall and flush events.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_id_rs1_addr  in  5  rs1 of instruction in ID
- i_id_rs2_addr  in  5  rs2 of instruction in ID
- i_id_use_rs1  in  1  ID instruction reads rs1
- i_id_use_rs2  in  1  ID instruction reads rs2
- i_ex_rd_addr  in  5  rd of instruction in EX
- i_ex_DM_OE  in  1  EX instruction is a load
- i_ex_redirect  in  1  EX resolved taken branch, jal or jalr
- i_im_busy  in  1  instruction fetch outstanding, response not yet returned
- i_dm_busy  in  1  MEM-stage data access not complete
- i_cnt_clr  in  1  clear all counters
- o_pc_en  out  1  PC loads next/target
- o_if_id_en  out  1  IF/ID captures
- o_if_id_flush  out  1  IF/ID loads bubble
- o_id_ex_en  out  1  ID/EX captures; low = hold
- o_id_ex_flush  out  1  ID/EX loads bubble (redirect)
- o_ex_stall  out  1  ID/EX loads bubble (hazard)
- o_ex_mem_en  out  1  EX/MEM captures
- o_mem_wb_en  out  1  MEM/WB captures
- o_if_drop  out  1  discard the current fetch response
- o_cnt_luse  out  CNT_W  load-use bubbles inserted
- o_cnt_flush  out  CNT_W  redirects committed
- o_cnt_bus  out  CNT_W  cycles frozen by i_dm_busy or i_im_busy

## Operation
- Load-use hazard (luse): i_ex_DM_OE, i_ex_rd_addr≠0, and (i_id_use_rs1 with rs1==rd, or i_id_use_rs2 with rs2==rd).
- FSM states: RUN, DROP. Reset enters RUN.
- RUN, decision in priority order:
  1. i_dm_busy: all enables 0, no flush or bubble. The redirect or luse stays pending because EX is frozen.
  2. i_ex_redirect: o_pc_en=1, o_if_id_flush=1, o_id_ex_flush=1, o_ex_mem_en=1, o_mem_wb_en=1. If i_im_busy is also 1, go to DROP.
  3. i_im_busy: o_pc_en=0, o_if_id_en=0, o_ex_stall=1, EX/MEM and MEM/WB enabled.
  4. luse: o_pc_en=0, o_if_id_en=0, o_ex_stall=1, EX/MEM and MEM/WB enabled.
  5. Otherwise: all enables 1, flush, bubble and drop 0.
- DROP:
  - o_pc_en=0, o_if_id_flush=1, o_ex_stall=1, o_if_drop=1.
  - EX/MEM and MEM/WB are enabled unless i_dm_busy.
  - When i_im_busy falls (the wrong-path response cycle), return to RUN next cycle. o_if_drop stays 1 in that response cycle.
  - An i_ex_redirect during DROP is ignored, because EX holds a bubble.
- "Enables 1" also means o_id_ex_en=1. o_id_ex_en=0 only under i_dm_busy.
- Counters:
  - o_cnt_luse increments in cycles where rule 4 fires.
  - o_cnt_flush increments in cycles where rule 2 fires.
  - o_cnt_bus increments in cycles where rule 1 or 3 fires, or in DROP while i_im_busy.
  - Counters wrap from 2^CNT_W−1 to 0.
  - i_cnt_clr has priority over increment: next value is 0.

## Timing
- Control outputs are combinational from state and inputs. State and counters are registered.
- While rst=1: control outputs forced to all enables 0, o_if_id_flush=1, o_id_ex_flush=1, o_ex_stall=0, o_if_drop=0. Counters are 0 the cycle after rst.
- Reset mid-DROP returns to RUN. The outstanding fetch is the fetch unit's responsibility.
- Load-use costs exactly 1 bubble. The next cycle the load is in MEM, so luse is false.
- Redirect squashes 2 slots (IF/ID, ID/EX), plus the DROP cycles if a fetch is outstanding.
- Redirect and luse in the same cycle: the redirect wins, and luse is not counted.

## Structure
- Shared package pipe_pkg holds:
  - typedef enum of the FSM states
  - struct pipe_ctrl_t bundling the stage enable, flush and bubble fields
  - constant REG_ZERO=5'd0
- Sub-module hazard_detect (combinational luse compare). The counters are inline.

## Test plan
- ID add x3,x1,x2 with EX lw x1; bus idle -> one cycle o_ex_stall=1, o_pc_en=0; o_cnt_luse 0→1; next cycle normal.
- EX lw x0, ID reads x0 -> no stall.
- i_ex_redirect=1 with buses idle -> o_if_id_flush=o_id_ex_flush=o_pc_en=1; o_cnt_flush +1; stays in RUN.
- i_ex_redirect with i_im_busy=1 for 3 more cycles -> DROP with o_if_drop=1 for 4 cycles (3 busy cycles plus the response cycle), then RUN; o_cnt_bus +3.
- i_dm_busy=1 for 5 cycles with redirect and luse both pending -> all enables 0 for 5 cycles; the redirect commits on cycle 6; o_cnt_bus +5; o_cnt_luse +0.
- CNT_W=4, o_cnt_bus at 15 plus one bus-stall cycle -> 0. i_cnt_clr together with an increment -> 0.
